count_sequencer: RTL and testbench
==================================

// Module: count_sequencer
// PURPOSE
//  Run/pause/clear controller for the 8-bit up-counter that drives the HEX0/HEX1 display.
//  Replaces the raw KEY/SW drive with the following sequencing:
//   - a rate-divided enable pulse;
//   - start/pause/resume and clear commands;
//   - a programmable terminal value, with wrap or stop-at-terminal modes.
//  Sits between the debounced KEY/SW inputs and the counter's Enable/Clear inputs.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency
//  TICK_HZ  1           counter advance rate; DIV = CLK_HZ/TICK_HZ, DIV >= 2
//  WIDTH    8           counter width
// PORTS
//  Clock   in   1      system clock; all logic on posedge
//  Reset   in   1      synchronous, active-high reset
//  Go      in   1      one-cycle pulse: start / pause / resume / restart
//  ClrReq  in   1      one-cycle pulse: abort and clear counter
//  Wrap    in   1      1 = wrap to 0 after Limit; 0 = stop at Limit
//  Limit   in   WIDTH  terminal count, sampled live
//  CntQ    in   WIDTH  current counter value (feedback)
//  Lap     in   1      display-hold toggle pulse (used only with LAP_HOLD_EN)
//  CntEn   out  1      counter increment enable, one-cycle pulse
//  CntClr  out  1      synchronous counter clear, active-high
//  DispQ   out  WIDTH  value for hex decoders
//  Running out  1      state == RUN
//  Done    out  1      state == DONE
//  State   out  2      IDLE=0, RUN=1, PAUSE=2, DONE=3
// BEHAVIOUR
//  Reset: State=IDLE; divider=0; CntEn=0; CntClr=1; Done=0; Running=0; lap hold cleared.
//  Outputs are registered. CntEn/CntClr pulses appear the cycle after the deciding edge.
//  Divider counts 0..DIV-1 only in RUN and holds its value in PAUSE.
//  Divider resets to 0 on entry to IDLE and on RUN entry from IDLE/DONE.
//  Tick = divider==DIV-1 in RUN.
//  IDLE : CntClr=1 every cycle. Go -> RUN.
//  RUN  : on tick, if CntQ >= Limit:
//           - Wrap=1 -> CntClr pulse, no CntEn (sequence 0..Limit,0,..)
//           - Wrap=0 -> DONE, no CntEn
//         otherwise CntEn pulse. Go -> PAUSE.
//  PAUSE: no CntEn/CntClr. Go -> RUN; divider resumes from its held value.
//  DONE : counter holds at Limit; Done=1. Go -> CntClr pulse, then RUN with divider=0.
//  ClrReq in any state -> IDLE.
//  Priority: Reset > ClrReq > Go > tick.
//   - Go coincident with tick in RUN -> PAUSE, no CntEn; divider holds at DIV-1.
//     First cycle after resume issues the tick.
//  Limit=0:
//   - Wrap=1 -> counter stays 0, CntClr each tick.
//   - Wrap=0 -> DONE on first tick.
//  Limit lowered below CntQ mid-run: the >= compare fires on the next tick.
//   - Wrap=1 -> counter cleared; Wrap=0 -> DONE.
//  Counter natural overflow (255->0) is impossible, because Limit <= 2^WIDTH-1 is compared first.
// CONFIGURATION
//  LAP_HOLD_EN defined:
//   - Lap pulse in RUN/PAUSE toggles hold.
//   - While hold is active, DispQ = CntQ snapshot registered at the toggle-on edge, and the counter keeps running.
//   - Hold is cleared on IDLE entry, on DONE entry, and on Reset.
//  LAP_HOLD_EN undefined: DispQ = CntQ (combinational passthrough); Lap ignored; no hold register.
// STRUCTURE
//  Package count_seq_pkg: state typedef (IDLE/RUN/PAUSE/DONE), WIDTH default, state encodings.
//  Sub-module rate_divider: counter with hold, clr, and tick outputs; parameter DIV.
//  FSM, compare and output registers live in count_sequencer.
// TESTING (CLK_HZ=4, TICK_HZ=1 -> DIV=4; bench models counter from CntEn/CntClr)
//  Reset, Go, Limit=5, Wrap=1
//   -> CntEn every 4th cycle; CntQ goes 0..5, then CntClr, then 0 again.
//   -> CntEn never asserted with CntQ=5.
//  Limit=3, Wrap=0, Go
//   -> CntQ reaches 3; next tick -> Done=1, State=3, no further CntEn.
//   -> Go -> CntClr pulse, State=1, CntQ restarts from 0.
//  Go in RUN at divider=2
//   -> State=2, no CntEn for 20 cycles.
//   -> Go -> CntEn exactly 2 cycles after resume (divider resumed at 2).
//  Go and ClrReq in the same cycle in RUN
//   -> State=0, CntClr=1, no CntEn.
//  Go coincident with tick
//   -> PAUSE, no CntEn; on resume, CntEn on the first cycle.
//  LAP_HOLD_EN, CntQ=7, Lap
//   -> DispQ stays 7 while CntQ advances to 9.
//   -> Lap -> DispQ=9.
//   -> ClrReq -> hold cleared, DispQ=0.

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: state encodings and default counter width.
package count_seq_pkg;

  localparam int WIDTH_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/count_seq_rate_divider.sv
// Rate divider for the count sequencer: counts 0..DIV-1 while advancing, holds otherwise,
// and flags the last count so the sequencer can issue its tick.
module rate_divider #(
  parameter int DIV = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr,
  input  logic adv,
  output logic at_last
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset || clr) begin
      count <= '0;
    end else if (adv) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign at_last = (count == LAST);

endmodule

// File: rtl/count_sequencer.sv
// Run/pause/clear sequencer driving the display up-counter's Enable/Clear inputs.
// Optional build macro LAP_HOLD_EN adds a lap-hold snapshot on the display output.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = WIDTH_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Go,
  input  logic             ClrReq,
  input  logic             Wrap,
  input  logic [WIDTH-1:0] Limit,
  input  logic [WIDTH-1:0] CntQ,
  input  logic             Lap,
  output logic             CntEn,
  output logic             CntClr,
  output logic [WIDTH-1:0] DispQ,
  output logic             Running,
  output logic             Done,
  output logic [1:0]       State
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  state_t state;
  state_t next_state;
  logic   en_d;
  logic   clr_d;
  logic   div_clr;
  logic   div_adv;
  logic   div_last;
  logic   tick;
  logic   at_limit;

  rate_divider #(.DIV(DIV)) u_div (
    .Clock   (Clock),
    .Reset   (Reset),
    .clr     (div_clr),
    .adv     (div_adv),
    .at_last (div_last)
  );

  assign tick     = (state == ST_RUN) && div_last;
  assign at_limit = (CntQ >= Limit);

  // ClrReq outranks Go, and Go outranks the tick; a Go on a tick edge leaves the
  // divider parked at its last count so the tick fires on the first resumed cycle.
  always_comb begin
    next_state = state;
    en_d       = 1'b0;
    clr_d      = 1'b0;
    div_clr    = 1'b0;
    div_adv    = 1'b0;
    if (ClrReq) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Go) begin
            next_state = ST_RUN;
            div_clr    = 1'b1;
          end
        end
        ST_RUN: begin
          if (Go) begin
            next_state = ST_PAUSE;
          end else begin
            div_adv = 1'b1;
            if (tick) begin
              if (!at_limit) en_d = 1'b1;
              else if (Wrap) clr_d = 1'b1;
              else next_state = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (Go) next_state = ST_RUN;
        end
        default: begin
          if (Go) begin
            next_state = ST_RUN;
            div_clr    = 1'b1;
            clr_d      = 1'b1;
          end
        end
      endcase
    end
    if (next_state == ST_IDLE) begin
      clr_d   = 1'b1;
      div_clr = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_IDLE;
      CntEn   <= 1'b0;
      CntClr  <= 1'b1;
      Running <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= next_state;
      CntEn   <= en_d;
      CntClr  <= clr_d;
      Running <= (next_state == ST_RUN);
      Done    <= (next_state == ST_DONE);
    end
  end

  assign State = state;

`ifdef LAP_HOLD_EN
  logic             hold;
  logic [WIDTH-1:0] snap;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      hold <= 1'b0;
      snap <= '0;
    end else if (next_state == ST_IDLE || next_state == ST_DONE) begin
      hold <= 1'b0;
    end else if (Lap && (state == ST_RUN || state == ST_PAUSE)) begin
      hold <= !hold;
      if (!hold) snap <= CntQ;
    end
  end

  assign DispQ = hold ? snap : CntQ;
`else
  logic unused_lap;
  assign unused_lap = Lap;
  assign DispQ      = CntQ;
`endif

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with DIV=4; the display counter is modelled from CntEn/CntClr.
module tb_count_sequencer;

  localparam int W = 8;

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic         go      = 1'b0;
  logic         clr_req = 1'b0;
  logic         wrap    = 1'b0;
  logic         lap     = 1'b0;
  logic [W-1:0] limit   = '0;
  logic [W-1:0] cnt_q   = '0;
  logic         cnt_en;
  logic         cnt_clr;
  logic         running;
  logic         done;
  logic [W-1:0] disp_q;
  logic [1:0]   state;

  int n_cmp = 0;
  int n_bad = 0;

  // clock/reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_clr) cnt_q <= '0;
    else if (cnt_en) cnt_q <= cnt_q + 1'b1;
  end

  count_sequencer #(.CLK_HZ(4), .TICK_HZ(1), .WIDTH(W)) dut (
    .Clock   (clk),
    .Reset   (rst),
    .Go      (go),
    .ClrReq  (clr_req),
    .Wrap    (wrap),
    .Limit   (limit),
    .CntQ    (cnt_q),
    .Lap     (lap),
    .CntEn   (cnt_en),
    .CntClr  (cnt_clr),
    .DispQ   (disp_q),
    .Running (running),
    .Done    (done),
    .State   (state)
  );

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_go();
    go = 1'b1;
    step(1);
    go = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_req = 1'b1;
    step(1);
    clr_req = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    step(1);
    lap = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_cmp++; if (cnt_clr !== 1'b1) begin n_bad++; $display("FAIL reset_cntclr got=%b exp=1", cnt_clr); end
    n_cmp++; if (cnt_en !== 1'b0) begin n_bad++; $display("FAIL reset_cnten got=%b exp=0", cnt_en); end
    n_cmp++; if ({running, done} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got=%b exp=00", {running, done}); end
    n_cmp++; if (disp_q !== 8'd0) begin n_bad++; $display("FAIL reset_dispq got=%0d exp=0", disp_q); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_wrap();
    int max_seen;
    logic exp_en, exp_clr;
    max_seen = 0;
    limit = 8'd5;
    wrap  = 1'b1;
    pulse_go();
    n_cmp++; if ({state, running} !== 3'b011) begin n_bad++; $display("FAIL wrap_start got=%b exp=011", {state, running}); end
    for (int i = 1; i <= 32; i++) begin
      step(1);
      exp_en  = (i % 4 == 0) && (i != 24);
      exp_clr = (i == 24);
      n_cmp++; if (cnt_en !== exp_en) begin n_bad++; $display("FAIL wrap_cnten cyc=%0d got=%b exp=%b", i, cnt_en, exp_en); end
      n_cmp++; if (cnt_clr !== exp_clr) begin n_bad++; $display("FAIL wrap_cntclr cyc=%0d got=%b exp=%b", i, cnt_clr, exp_clr); end
      n_cmp++; if (cnt_en && cnt_q == 8'd5) begin n_bad++; $display("FAIL wrap_en_at_limit cyc=%0d got=1 exp=0", i); end
      if (int'(cnt_q) > max_seen) max_seen = int'(cnt_q);
    end
    n_cmp++; if (max_seen != 5) begin n_bad++; $display("FAIL wrap_max got=%0d exp=5", max_seen); end
    n_cmp++; if (cnt_q !== 8'd1) begin n_bad++; $display("FAIL wrap_final_cnt got=%0d exp=1", cnt_q); end
    pulse_clr();
    n_cmp++; if ({state, cnt_clr} !== 3'b001) begin n_bad++; $display("FAIL wrap_clr got=%b exp=001", {state, cnt_clr}); end
    step(1);
    n_cmp++; if (cnt_q !== 8'd0) begin n_bad++; $display("FAIL wrap_clr_cnt got=%0d exp=0", cnt_q); end
  endtask

  task automatic test_done();
    logic exp_en;
    limit = 8'd3;
    wrap  = 1'b0;
    pulse_go();
    for (int i = 1; i <= 16; i++) begin
      step(1);
      exp_en = (i % 4 == 0) && (i < 16);
      n_cmp++; if (cnt_en !== exp_en) begin n_bad++; $display("FAIL done_cnten cyc=%0d got=%b exp=%b", i, cnt_en, exp_en); end
    end
    n_cmp++; if ({state, done, running} !== 4'b1110) begin n_bad++; $display("FAIL done_entry got=%b exp=1110", {state, done, running}); end
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_cmp++; if (cnt_en !== 1'b0) begin n_bad++; $display("FAIL done_hold_cnten cyc=%0d got=%b exp=0", i, cnt_en); end
    end
    n_cmp++; if (cnt_q !== 8'd3 || disp_q !== 8'd3) begin n_bad++; $display("FAIL done_hold_val got=%0d/%0d exp=3/3", cnt_q, disp_q); end
    pulse_go();
    n_cmp++; if ({state, cnt_clr} !== 3'b011) begin n_bad++; $display("FAIL done_restart got=%b exp=011", {state, cnt_clr}); end
    step(1);
    n_cmp++; if (cnt_q !== 8'd0 || cnt_clr !== 1'b0) begin n_bad++; $display("FAIL done_restart_cnt got=%0d/%b exp=0/0", cnt_q, cnt_clr); end
    for (int i = 2; i <= 4; i++) begin
      step(1);
      exp_en = (i == 4);
      n_cmp++; if (cnt_en !== exp_en) begin n_bad++; $display("FAIL done_restart_en cyc=%0d got=%b exp=%b", i, cnt_en, exp_en); end
    end
    pulse_clr();
    step(1);
  endtask

  task automatic test_pause();
    limit = 8'd200;
    wrap  = 1'b1;
    pulse_go();
    step(2);
    pulse_go();
    n_cmp++; if ({state, cnt_en} !== 3'b100) begin n_bad++; $display("FAIL pause_entry got=%b exp=100", {state, cnt_en}); end
    for (int i = 0; i < 20; i++) begin
      step(1);
      n_cmp++; if ({state, cnt_en, cnt_clr} !== 4'b1000) begin n_bad++; $display("FAIL pause_hold cyc=%0d got=%b exp=1000", i, {state, cnt_en, cnt_clr}); end
    end
    pulse_go();
    n_cmp++; if ({state, cnt_en} !== 3'b010) begin n_bad++; $display("FAIL pause_resume got=%b exp=010", {state, cnt_en}); end
    step(1);
    n_cmp++; if (cnt_en !== 1'b0) begin n_bad++; $display("FAIL pause_resume_c1 got=%b exp=0", cnt_en); end
    step(1);
    n_cmp++; if (cnt_en !== 1'b1) begin n_bad++; $display("FAIL pause_resume_c2 got=%b exp=1", cnt_en); end
  endtask

  task automatic test_go_clr_same();
    go      = 1'b1;
    clr_req = 1'b1;
    step(1);
    go      = 1'b0;
    clr_req = 1'b0;
    n_cmp++; if ({state, cnt_clr, cnt_en, running} !== 5'b00100) begin n_bad++; $display("FAIL goclr_same got=%b exp=00100", {state, cnt_clr, cnt_en, running}); end
    step(4);
    n_cmp++; if (state !== 2'd0 || cnt_q !== 8'd0 || cnt_en !== 1'b0) begin n_bad++; $display("FAIL goclr_idle got=%0d/%0d/%b exp=0/0/0", state, cnt_q, cnt_en); end
  endtask

  task automatic test_go_on_tick();
    limit = 8'd200;
    wrap  = 1'b1;
    pulse_go();
    step(3);
    pulse_go();
    n_cmp++; if ({state, cnt_en} !== 3'b100) begin n_bad++; $display("FAIL gotick_pause got=%b exp=100", {state, cnt_en}); end
    step(5);
    n_cmp++; if (cnt_en !== 1'b0 || cnt_q !== 8'd0) begin n_bad++; $display("FAIL gotick_hold got=%b/%0d exp=0/0", cnt_en, cnt_q); end
    pulse_go();
    n_cmp++; if ({state, cnt_en} !== 3'b010) begin n_bad++; $display("FAIL gotick_resume got=%b exp=010", {state, cnt_en}); end
    step(1);
    n_cmp++; if (cnt_en !== 1'b1) begin n_bad++; $display("FAIL gotick_first got=%b exp=1", cnt_en); end
    pulse_clr();
    step(1);
  endtask

  task automatic test_limit();
    logic exp_clr;
    limit = 8'd0;
    wrap  = 1'b1;
    pulse_go();
    for (int i = 1; i <= 8; i++) begin
      step(1);
      exp_clr = (i % 4 == 0);
      n_cmp++; if ({cnt_en, cnt_clr} !== {1'b0, exp_clr}) begin n_bad++; $display("FAIL lim0_wrap cyc=%0d got=%b exp=0%b", i, {cnt_en, cnt_clr}, exp_clr); end
    end
    wrap = 1'b0;
    step(3);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL lim0_stop_pre got=%0d exp=1", state); end
    step(1);
    n_cmp++; if ({state, done, cnt_en} !== 4'b1110) begin n_bad++; $display("FAIL lim0_stop got=%b exp=1110", {state, done, cnt_en}); end
    pulse_clr();
    step(1);
    limit = 8'd10;
    wrap  = 1'b1;
    pulse_go();
    step(17);
    n_cmp++; if (cnt_q !== 8'd4) begin n_bad++; $display("FAIL lower_pre got=%0d exp=4", cnt_q); end
    limit = 8'd2;
    step(2);
    n_cmp++; if ({cnt_en, cnt_clr} !== 2'b00) begin n_bad++; $display("FAIL lower_wait got=%b exp=00", {cnt_en, cnt_clr}); end
    step(1);
    n_cmp++; if ({cnt_en, cnt_clr} !== 2'b01) begin n_bad++; $display("FAIL lower_tick got=%b exp=01", {cnt_en, cnt_clr}); end
    step(1);
    n_cmp++; if (cnt_q !== 8'd0) begin n_bad++; $display("FAIL lower_cnt got=%0d exp=0", cnt_q); end
    pulse_clr();
    step(1);
  endtask

  task automatic test_lap();
    limit = 8'd200;
    wrap  = 1'b1;
    pulse_go();
    step(29);
    n_cmp++; if (cnt_q !== 8'd7) begin n_bad++; $display("FAIL lap_pre got=%0d exp=7", cnt_q); end
    pulse_lap();
`ifdef LAP_HOLD_EN
    n_cmp++; if (disp_q !== 8'd7) begin n_bad++; $display("FAIL lap_on got=%0d exp=7", disp_q); end
    for (int i = 0; i < 7; i++) begin
      step(1);
      n_cmp++; if (disp_q !== 8'd7) begin n_bad++; $display("FAIL lap_hold cyc=%0d got=%0d exp=7", i, disp_q); end
    end
    n_cmp++; if (cnt_q !== 8'd9) begin n_bad++; $display("FAIL lap_cnt_runs got=%0d exp=9", cnt_q); end
    pulse_lap();
    n_cmp++; if (disp_q !== 8'd9) begin n_bad++; $display("FAIL lap_off got=%0d exp=9", disp_q); end
    pulse_lap();
    step(4);
    n_cmp++; if (disp_q !== 8'd9 || cnt_q !== 8'd10) begin n_bad++; $display("FAIL lap_rehold got=%0d/%0d exp=9/10", disp_q, cnt_q); end
    pulse_clr();
    n_cmp++; if (disp_q !== 8'd10) begin n_bad++; $display("FAIL lap_clr_release got=%0d exp=10", disp_q); end
`else
    n_cmp++; if (disp_q !== 8'd7) begin n_bad++; $display("FAIL lap_ignored got=%0d exp=7", disp_q); end
    step(7);
    n_cmp++; if (disp_q !== 8'd9) begin n_bad++; $display("FAIL lap_passthru got=%0d exp=9", disp_q); end
    pulse_clr();
`endif
    step(1);
    n_cmp++; if (disp_q !== 8'd0) begin n_bad++; $display("FAIL lap_clr_disp got=%0d exp=0", disp_q); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_done();
    test_pause();
    test_go_clr_same();
    test_go_on_tick();
    test_limit();
    test_lap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
